// File: rtl/cdb_pkg.sv
// Shared widths, result-kind encoding and result-entry layout for the CDB stage.
// No logic; imported by the arbiter, its interface users and the bench.
// Entry fields mirror what a functional unit hands over on completion.
package cdb_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_NUM_SRC = 4;

    typedef enum logic {
        KIND_REG   = 1'b0,
        KIND_STORE = 1'b1
    } kind_e;

    typedef struct packed {
        kind_e                  kind;
        logic [DEF_TAG_W-1:0]   tag;
        logic [DEF_DATA_W-1:0]  data;
        logic [DEF_ADDR_W-1:0]  addr;
    } entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side channels plus CDB broadcast and data-memory write port.
// master = producers/observers, slave = the arbiter stage.
// src_ready is the only backpressure; CDB and memory never stall.
interface cdb_arbiter_if #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 4,
    parameter int ADDR_W  = 4,
    parameter int NUM_SRC = 4
);
    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC-1:0]        src_store;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;

    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [IDX_W-1:0]          grant_src;

    modport master (
        output src_valid, src_store, src_tag, src_data, src_addr,
        input  src_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        input  mem_we, mem_addr, mem_wdata, grant_src
    );

    modport slave (
        input  src_valid, src_store, src_tag, src_data, src_addr,
        output src_ready,
        output cdb_valid, cdb_tag, cdb_data,
        output mem_we, mem_addr, mem_wdata, grant_src
    );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Round-robin picker: first set req at or above ptr, wrapping modulo NUM_SRC.
// Purely combinational, zero latency.
// No backpressure; any=0 when nothing is requesting.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-channel CDB stage: one holding entry per producer, round-robin grant per cycle.
// Latency: accepted at edge E, earliest grant in the next cycle, visible after E+1.
// Backpressure: src_ready[i] = entry empty or being granted; CDB/memory always accept.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_SRC = DEF_NUM_SRC
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] hold_v;
    kind_e              hold_kind [NUM_SRC];
    logic [TAG_W-1:0]   hold_tag  [NUM_SRC];
    logic [DATA_W-1:0]  hold_data [NUM_SRC];
    logic [ADDR_W-1:0]  hold_addr [NUM_SRC];

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0] grant;
    logic [IDX_W-1:0]   gidx;
    logic               gany;
    logic [NUM_SRC-1:0] src_rdy;
    logic [NUM_SRC-1:0] load;

    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_data_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [IDX_W-1:0]   grant_src_q;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (hold_v),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // A granted entry drains this edge, so it can take a new result at the same time.
    assign src_rdy = ~hold_v | grant;
    assign load    = bus.src_valid & src_rdy;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_v      <= '0;
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_src_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (load[i]) begin
                    hold_v[i] <= 1'b1;
                end else if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end

            if (gany) begin
                rr_ptr      <= (gidx == IDX_W'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
                grant_src_q <= gidx;
                if (hold_kind[gidx] == KIND_STORE) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= hold_addr[gidx];
                    mem_wdata_q <= hold_data[gidx];
                    cdb_valid_q <= 1'b0;
                end else begin
                    cdb_valid_q <= 1'b1;
                    cdb_tag_q   <= hold_tag[gidx];
                    cdb_data_q  <= hold_data[gidx];
                    mem_we_q    <= 1'b0;
                end
            end else begin
                cdb_valid_q <= 1'b0;
                mem_we_q    <= 1'b0;
            end
        end
    end

    // Payload only matters while hold_v is set, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load[i]) begin
                hold_kind[i] <= bus.src_store[i] ? KIND_STORE : KIND_REG;
                hold_tag[i]  <= bus.src_tag[i*TAG_W +: TAG_W];
                hold_data[i] <= bus.src_data[i*DATA_W +: DATA_W];
                hold_addr[i] <= bus.src_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign bus.src_ready = src_rdy;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant_src = grant_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected results are queued as stimulus is driven
// and popped by a monitor whenever the CDB or memory port fires.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int DATA_W  = DEF_DATA_W;
    localparam int TAG_W   = DEF_TAG_W;
    localparam int ADDR_W  = DEF_ADDR_W;
    localparam int NUM_SRC = DEF_NUM_SRC;

    localparam logic [3:0] RDY6 [5] = '{4'hF, 4'hE, 4'h7, 4'hF, 4'hF};

    typedef struct {
        entry_t e;
        int     src;
    } exp_t;

    logic clock;
    logic reset;
    int   n_total;
    int   n_pass;
    exp_t sb [$];

    cdb_arbiter_if #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC)
    ) bus ();

    cdb_arbiter #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input kind_e kd,
                         input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] a);
        bus.src_valid[i]                  = v;
        bus.src_store[i]                  = (kd == KIND_STORE);
        bus.src_tag[i*TAG_W +: TAG_W]     = t;
        bus.src_data[i*DATA_W +: DATA_W]  = d;
        bus.src_addr[i*ADDR_W +: ADDR_W]  = a;
    endtask

    task automatic push(input int src, input kind_e kd, input logic [TAG_W-1:0] t,
                        input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        exp_t x;
        x.e.kind = kd;
        x.e.tag  = t;
        x.e.data = d;
        x.e.addr = a;
        x.src    = src;
        sb.push_back(x);
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 50; c++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
        end
        repeat (2) @(posedge clock);
        #1;
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (bus.cdb_valid === 1'b1 || bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, bus.mem_we, bus.cdb_valid}, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("grant_src", 32'(bus.grant_src), 32'(x.src));
                if (x.e.kind == KIND_STORE) begin
                    chk("store_mem_we", 32'(bus.mem_we), 32'd1);
                    chk("store_cdb_quiet", 32'(bus.cdb_valid), 32'd0);
                    chk("store_addr", 32'(bus.mem_addr), 32'(x.e.addr));
                    chk("store_wdata", 32'(bus.mem_wdata), 32'(x.e.data));
                end else begin
                    chk("reg_cdb_valid", 32'(bus.cdb_valid), 32'd1);
                    chk("reg_mem_quiet", 32'(bus.mem_we), 32'd0);
                    chk("reg_tag", 32'(bus.cdb_tag), 32'(x.e.tag));
                    chk("reg_data", 32'(bus.cdb_data), 32'(x.e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k [NUM_SRC];
        int kb;
        logic [3:0] exp_rdy;

        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        bus.src_valid = '0;
        bus.src_store = '0;
        bus.src_tag   = '0;
        bus.src_data  = '0;
        bus.src_addr  = '0;

        // Reset state and idle outputs
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        chk("rst_cdb_tag",   32'(bus.cdb_tag),   32'd0);
        chk("rst_cdb_data",  32'(bus.cdb_data),  32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_grant_src", 32'(bus.grant_src), 32'd0);
        chk("rst_src_ready", 32'(bus.src_ready), 32'hF);
        cyc();

        // Single ALU result on channel 2: latency and one-cycle pulse
        drive(2, 1'b1, KIND_REG, 4'd5, 16'h1234, 4'd0);
        push(2, KIND_REG, 4'd5, 16'h1234, 4'd0);
        cyc();
        bus.src_valid[2] = 1'b0;
        @(negedge clock);
        chk("alu_not_yet", 32'(bus.cdb_valid), 32'd0);
        cyc();
        @(negedge clock);
        chk("alu_visible", 32'(bus.cdb_valid), 32'd1);
        cyc();
        @(negedge clock);
        chk("alu_pulse_end", 32'(bus.cdb_valid), 32'd0);

        // Store on channel 1
        drive(1, 1'b1, KIND_STORE, 4'd0, 16'hBEEF, 4'hA);
        push(1, KIND_STORE, 4'd0, 16'hBEEF, 4'hA);
        cyc();
        bus.src_valid[1] = 1'b0;
        cyc();
        @(negedge clock);
        chk("store_we", 32'(bus.mem_we), 32'd1);
        chk("store_no_cdb", 32'(bus.cdb_valid), 32'd0);
        cyc();
        @(negedge clock);
        chk("store_pulse_end", 32'(bus.mem_we), 32'd0);

        // Reset while all entries are full: nothing may be broadcast
        for (int i = 0; i < NUM_SRC; i++) drive(i, 1'b1, KIND_REG, 4'(12 + i), 16'hDEAD, 4'd0);
        cyc();
        bus.src_valid = '0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ready", 32'(bus.src_ready), 32'hF);
        chk("midrst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        chk("midrst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("midrst_grant_src", 32'(bus.grant_src), 32'd0);
        repeat (6) cyc();

        // All channels saturated: grants rotate 0,1,2,3 with refill-on-grant
        for (int i = 0; i < NUM_SRC; i++) begin
            k[i] = 0;
            drive(i, 1'b1, KIND_REG, 4'(i*4), 16'(16'h5000 + i*256), 4'd0);
        end
        for (int n = 0; n < 16; n++) begin
            @(negedge clock);
            exp_rdy = (n == 0) ? 4'hF : 4'(1 << ((n - 1) % 4));
            chk("sat_ready", 32'(bus.src_ready), 32'(exp_rdy));
            for (int i = 0; i < NUM_SRC; i++) begin
                if (exp_rdy[i]) push(i, KIND_REG, 4'(i*4 + k[i]%4), 16'(16'h5000 + i*256 + k[i]), 4'd0);
            end
            cyc();
            for (int i = 0; i < NUM_SRC; i++) begin
                if (exp_rdy[i]) begin
                    k[i]++;
                    drive(i, 1'b1, KIND_REG, 4'(i*4 + k[i]%4), 16'(16'h5000 + i*256 + k[i]), 4'd0);
                end
            end
        end
        bus.src_valid = '0;
        wait_drain("sat_drain");

        // rr_ptr=3: channel 3 continuous plus a one-shot on channel 0
        kb = 0;
        drive(3, 1'b1, KIND_REG, 4'd10, 16'h3300, 4'd0);
        drive(0, 1'b1, KIND_REG, 4'd2, 16'h0A0A, 4'd0);
        push(3, KIND_REG, 4'd10, 16'h3300, 4'd0);
        push(0, KIND_REG, 4'd2,  16'h0A0A, 4'd0);
        push(3, KIND_REG, 4'd11, 16'h3301, 4'd0);
        push(3, KIND_REG, 4'd12, 16'h3302, 4'd0);
        push(3, KIND_REG, 4'd13, 16'h3303, 4'd0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk("wrap_ready", 32'(bus.src_ready), 32'(RDY6[n]));
            cyc();
            if (n == 0) bus.src_valid[0] = 1'b0;
            if (RDY6[n][3]) begin
                kb++;
                drive(3, 1'b1, KIND_REG, 4'(10 + kb), 16'(16'h3300 + kb), 4'd0);
            end
        end
        bus.src_valid[3] = 1'b0;
        wait_drain("wrap_drain");

        // Channel 0 full while others win: blocked until its own grant, refilled then
        drive(1, 1'b1, KIND_REG,   4'd1, 16'h1111, 4'd0);
        drive(2, 1'b1, KIND_STORE, 4'd0, 16'h2222, 4'd3);
        push(1, KIND_REG,   4'd1, 16'h1111, 4'd0);
        push(2, KIND_STORE, 4'd0, 16'h2222, 4'd3);
        push(0, KIND_REG,   4'd7, 16'hC0C0, 4'd0);
        push(0, KIND_REG,   4'd8, 16'hC1C1, 4'd0);
        @(negedge clock);
        chk("blk_ready0", 32'(bus.src_ready), 32'hF);
        cyc();
        bus.src_valid[1] = 1'b0;
        bus.src_valid[2] = 1'b0;
        drive(0, 1'b1, KIND_REG, 4'd7, 16'hC0C0, 4'd0);
        @(negedge clock);
        chk("blk_ready1", 32'(bus.src_ready), 32'hB);
        cyc();
        drive(0, 1'b1, KIND_REG, 4'd8, 16'hC1C1, 4'd0);
        @(negedge clock);
        chk("blk_ready2", 32'(bus.src_ready), 32'hE);
        chk("blk_ch0_stalled", 32'(bus.src_ready[0]), 32'd0);
        cyc();
        @(negedge clock);
        chk("blk_ready3", 32'(bus.src_ready), 32'hF);
        cyc();
        bus.src_valid[0] = 1'b0;
        wait_drain("blk_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
